// File: rtl/imem_fetch_port_pkg.sv
// imem_pkg: shared types and helpers for the instruction-memory fetch port.
//   INSTR_W     instruction width carried in a buffered response
//   NOP_INSTR   instruction returned on an error response
//   WIDX_W      width of the word-index arithmetic (wide enough for any ADDR_W <= 64)
//   imem_rsp_t  one buffered response: instruction word plus error flag
//   word_index  byte address -> word index (byte_mode=1) or pass-through (byte_mode=0)
package imem_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam int WIDX_W = 64;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic               err;
   } imem_rsp_t;

   function automatic logic [WIDX_W-1:0] word_index(input logic [WIDX_W-1:0] addr,
                                                    input logic              byte_mode);
      return byte_mode ? (addr >> 2) : addr;
   endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// imem_fetch_port_if: valid/ready fetch bus between the IF stage and instruction memory.
//   req_valid/req_ready/req_addr   fetch request channel (core -> memory)
//   rsp_valid/rsp_ready            response handshake (memory -> core)
//   rsp_instr/rsp_err              response payload
//   modport master: core side; modport slave: memory side
interface imem_fetch_port_if
   import imem_pkg::*;
#(
   parameter int DATA_W = INSTR_W,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_instr;
   logic              rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_err
   );
endinterface

// File: rtl/imem_rsp_fifo2.sv
// imem_rsp_fifo2: 2-entry in-order response buffer.
//   clk, rst_n   clock, asynchronous active-low reset (control state only)
//   push         write push_data this cycle (caller guarantees count < 2 or pop)
//   pop          drop head this cycle (caller guarantees count > 0)
//   head         oldest entry (meaningless when count == 0)
//   count        number of valid entries, 0..2
module imem_rsp_fifo2
   import imem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  imem_rsp_t   push_data,
   input  logic        pop,
   output imem_rsp_t   head,
   output logic [1:0]  count
);

   imem_rsp_t slot_q [2];
   logic      wr_ptr;
   logic      rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) slot_q[wr_ptr] <= push_data;
   end

   assign head = slot_q[rd_ptr];

endmodule

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: synchronous instruction memory with a valid/ready fetch port.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (released synchronously internally)
//   fp         fetch bus, slave side (request in, response out)
//   ld_en      program-load write enable; blocks fetches while high
//   ld_addr    load word index (indices >= DEPTH are ignored)
//   ld_data    load data
// A request accepted at edge N reads memory at edge N+1 straight into the response
// buffer, so the response is visible in cycle N+1. Error requests skip the read and
// buffer a NOP with rsp_err set, keeping latency and order unchanged.
module imem_fetch_port
   import imem_pkg::*;
#(
   parameter int DATA_W    = INSTR_W,
   parameter int ADDR_W    = 32,
   parameter int DEPTH     = 256,
   parameter int BYTE_ADDR = 1,
   localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic              clk,
   input  logic              rst_n,
   imem_fetch_port_if.slave  fp,
   input  logic              ld_en,
   input  logic [IDX_W-1:0]  ld_addr,
   input  logic [DATA_W-1:0] ld_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Reset: assert asynchronously, release two edges later in step with clk.
   logic [1:0] rst_sync;
   logic       rst_i_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_i_n = rst_sync[1];

   // ---- p0: request decode and accept ----
   logic [WIDX_W-1:0] w_p0;
   logic              err_p0;
   logic              acc_p0;
   logic              pop;
   logic [1:0]        count;
   logic [2:0]        occ;
   logic              vld_p1;
   logic [IDX_W-1:0]  idx_p1;
   logic              err_p1;
   imem_rsp_t         push_data;
   imem_rsp_t         head;

   assign w_p0   = word_index(WIDX_W'(fp.req_addr), BYTE_ADDR != 0);
   assign err_p0 = ((BYTE_ADDR != 0) && (fp.req_addr[1:0] != 2'b00))
                || (w_p0 >= WIDX_W'(DEPTH));

   assign pop    = fp.rsp_valid && fp.rsp_ready;
   // Occupancy after the next edge if nothing new is accepted. Crediting the pop
   // lets a steady stream run at one fetch per cycle without exceeding two slots.
   assign occ    = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
   assign fp.req_ready = !ld_en && (occ < 3'd2);
   assign acc_p0 = fp.req_valid && fp.req_ready;

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) vld_p1 <= 1'b0;
      else          vld_p1 <= acc_p0;
   end

   always_ff @(posedge clk) begin
      if (acc_p0) begin
         idx_p1 <= w_p0[IDX_W-1:0];
         err_p1 <= err_p0;
      end
   end

   // ---- p1: memory read into the response buffer ----
   // Nonblocking load write means a read on the same edge sees the old word.
   always_ff @(posedge clk) begin
      if (ld_en && (32'(ld_addr) < 32'(DEPTH))) mem[ld_addr] <= ld_data;
   end

   assign push_data.instr = err_p1 ? NOP_INSTR : INSTR_W'(mem[idx_p1]);
   assign push_data.err   = err_p1;

   imem_rsp_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst_i_n),
      .push      (vld_p1),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   // ---- response outputs ----
   // Payload is forced to zero when empty so reset shows rsp_instr=0, rsp_err=0.
   assign fp.rsp_valid = (count != 2'd0);
   assign fp.rsp_instr = fp.rsp_valid ? DATA_W'(head.instr) : '0;
   assign fp.rsp_err   = fp.rsp_valid && head.err;

endmodule

// File: tb/tb_imem_fetch_port.sv
module tb_imem_fetch_port;

   logic        clk;
   logic        rst_n;
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;

   int n_tests;
   int n_fail;

   logic [31:0] s_addr  [8];
   logic [31:0] s_instr [8];
   logic        s_err   [8];

   imem_fetch_port_if #(.DATA_W(32), .ADDR_W(32)) fp_if ();

   imem_fetch_port #(
      .DATA_W    (32),
      .ADDR_W    (32),
      .DEPTH     (256),
      .BYTE_ADDR (1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .fp      (fp_if),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic load_word(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   // Back-to-back stream of n requests with rsp_ready=1; response k must be
   // visible exactly two negedges after its request was driven.
   task automatic run_stream(input int n, input string tag);
      for (int k = 0; k < n + 3; k++) begin
         @(negedge clk);
         if (k < n) begin
            fp_if.req_valid = 1'b1;
            fp_if.req_addr  = s_addr[k];
         end else begin
            fp_if.req_valid = 1'b0;
         end
         #1;
         if (k < n) chk({tag, "_ready"}, 32'(fp_if.req_ready), 32'd1);
         if (k >= 2 && k < n + 2) begin
            chk({tag, "_valid"}, 32'(fp_if.rsp_valid), 32'd1);
            chk({tag, "_instr"}, fp_if.rsp_instr, s_instr[k-2]);
            chk({tag, "_err"},   32'(fp_if.rsp_err), 32'(s_err[k-2]));
         end else begin
            chk({tag, "_idle"}, 32'(fp_if.rsp_valid), 32'd0);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      ld_en   = 1'b0;
      ld_addr = 8'd0;
      ld_data = 32'd0;
      fp_if.req_valid = 1'b0;
      fp_if.req_addr  = 32'd0;
      fp_if.rsp_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_valid", 32'(fp_if.rsp_valid), 32'd0);
      chk("rst_instr", fp_if.rsp_instr, 32'd0);
      chk("rst_err",   32'(fp_if.rsp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1: program load and sequential byte-address fetch
      load_word(8'd0,   32'h2008_0005);
      load_word(8'd1,   32'h2009_0003);
      load_word(8'd2,   32'h0109_5020);
      load_word(8'd3,   32'hAC0A_0000);
      load_word(8'd4,   32'h0800_0000);
      load_word(8'd255, 32'hDEAD_BEEF);
      s_addr[0] = 32'd0;  s_instr[0] = 32'h2008_0005; s_err[0] = 1'b0;
      s_addr[1] = 32'd4;  s_instr[1] = 32'h2009_0003; s_err[1] = 1'b0;
      s_addr[2] = 32'd8;  s_instr[2] = 32'h0109_5020; s_err[2] = 1'b0;
      s_addr[3] = 32'd12; s_instr[3] = 32'hAC0A_0000; s_err[3] = 1'b0;
      s_addr[4] = 32'd16; s_instr[4] = 32'h0800_0000; s_err[4] = 1'b0;
      run_stream(5, "seq");

      // 2: misaligned addresses interleaved with valid fetches
      s_addr[0] = 32'h1; s_instr[0] = 32'h0000_0000; s_err[0] = 1'b1;
      s_addr[1] = 32'h4; s_instr[1] = 32'h2009_0003; s_err[1] = 1'b0;
      s_addr[2] = 32'h7; s_instr[2] = 32'h0000_0000; s_err[2] = 1'b1;
      s_addr[3] = 32'h8; s_instr[3] = 32'h0109_5020; s_err[3] = 1'b0;
      run_stream(4, "mis");

      // 3: range boundary
      s_addr[0] = 32'h400; s_instr[0] = 32'h0000_0000; s_err[0] = 1'b1;
      s_addr[1] = 32'h3FC; s_instr[1] = 32'hDEAD_BEEF; s_err[1] = 1'b0;
      s_addr[2] = 32'h404; s_instr[2] = 32'h0000_0000; s_err[2] = 1'b1;
      run_stream(3, "rng");

      // 4: backpressure
      @(negedge clk);
      fp_if.rsp_ready = 1'b0;
      fp_if.req_valid = 1'b1;
      fp_if.req_addr  = 32'd0;
      #1 chk("bp_ready0", 32'(fp_if.req_ready), 32'd1);
      @(negedge clk);
      fp_if.req_addr  = 32'd4;
      #1 chk("bp_ready1", 32'(fp_if.req_ready), 32'd1);
      @(negedge clk);
      fp_if.req_addr  = 32'd8;
      #1 chk("bp_ready2", 32'(fp_if.req_ready), 32'd0);
      chk("bp_hold_a", fp_if.rsp_instr, 32'h2008_0005);
      @(negedge clk);
      #1 chk("bp_ready3", 32'(fp_if.req_ready), 32'd0);
      chk("bp_hold_b", fp_if.rsp_instr, 32'h2008_0005);
      chk("bp_hold_v", 32'(fp_if.rsp_valid), 32'd1);
      @(negedge clk);
      fp_if.rsp_ready = 1'b1;
      #1 chk("bp_release", 32'(fp_if.req_ready), 32'd1);
      chk("bp_out0", fp_if.rsp_instr, 32'h2008_0005);
      @(negedge clk);
      fp_if.req_valid = 1'b0;
      #1 chk("bp_out1", fp_if.rsp_instr, 32'h2009_0003);
      @(negedge clk);
      #1 chk("bp_out2", fp_if.rsp_instr, 32'h0109_5020);
      chk("bp_out2_v", 32'(fp_if.rsp_valid), 32'd1);
      @(negedge clk);
      #1 chk("bp_empty", 32'(fp_if.rsp_valid), 32'd0);

      // 5: load colliding with an in-flight fetch of the same word
      @(negedge clk);
      fp_if.req_valid = 1'b1;
      fp_if.req_addr  = 32'd8;
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'd2;
      ld_data = 32'h1234_5678;
      #1 chk("ld_block", 32'(fp_if.req_ready), 32'd0);
      @(negedge clk);
      ld_en = 1'b0;
      #1 chk("ld_ready", 32'(fp_if.req_ready), 32'd1);
      chk("ld_old", fp_if.rsp_instr, 32'h0109_5020);
      @(negedge clk);
      fp_if.req_valid = 1'b0;
      #1 chk("ld_gap", 32'(fp_if.rsp_valid), 32'd0);
      @(negedge clk);
      #1 chk("ld_new", fp_if.rsp_instr, 32'h1234_5678);
      chk("ld_new_v", 32'(fp_if.rsp_valid), 32'd1);
      @(negedge clk);
      #1 chk("ld_done", 32'(fp_if.rsp_valid), 32'd0);

      // 6: reset with a buffered response and a fetch in flight
      @(negedge clk);
      fp_if.rsp_ready = 1'b0;
      fp_if.req_valid = 1'b1;
      fp_if.req_addr  = 32'd0;
      @(negedge clk);
      fp_if.req_addr  = 32'd4;
      @(negedge clk);
      fp_if.req_valid = 1'b0;
      #1 chk("mr_pre_v", 32'(fp_if.rsp_valid), 32'd1);
      rst_n = 1'b0;
      #1 chk("mr_drop_v", 32'(fp_if.rsp_valid), 32'd0);
      chk("mr_drop_i", fp_if.rsp_instr, 32'd0);
      chk("mr_drop_e", 32'(fp_if.rsp_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      fp_if.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 chk("mr_stale", 32'(fp_if.rsp_valid), 32'd0);
      end
      s_addr[0] = 32'd0;  s_instr[0] = 32'h2008_0005; s_err[0] = 1'b0;
      s_addr[1] = 32'd8;  s_instr[1] = 32'h1234_5678; s_err[1] = 1'b0;
      s_addr[2] = 32'd16; s_instr[2] = 32'h0800_0000; s_err[2] = 1'b0;
      run_stream(3, "mr_keep");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
